// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// buffers the returned word in an output register and hands it to the
// decoder with a valid/ready handshake. Branch redirects squash the
// in-flight or buffered instruction and restart fetching at the target.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_FULL = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_issue_pc;
  logic        r_drop;
  logic        w_drop_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic [15:0] r_instr_count;

  logic        w_req;
  logic        w_grant;
  logic        w_load;
  logic        w_xfer;
  logic [31:0] w_redirect_tgt;

  // Handshake qualifiers; a redirect overrides every other event this cycle.
  always_comb begin
    w_req          = rst & (r_state == S_IDLE) & ~halt & ~redirect;
    w_grant        = w_req & imem_gnt;
    w_load         = (r_state == S_WAIT) & imem_rvalid & ~r_drop & ~redirect;
    w_xfer         = (r_state == S_FULL) & r_instr_valid & instr_ready & ~redirect;
    w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  end

  // Next-state and drop-flag logic for the IDLE/WAIT/FULL fetch FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_drop_nxt = 1'b0;
          if (redirect || r_drop) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FULL;
          end
        end else begin
          w_state_nxt = S_WAIT;
          if (redirect) begin
            w_drop_nxt = 1'b1;
          end else begin
            w_drop_nxt = r_drop;
          end
        end
      end
      S_FULL: begin
        if (redirect || w_xfer) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FULL;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  // State register and the drop flag for a squashed outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Fetch pointer: jump on redirect, advance by one word on each grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_issue_pc <= 32'h0000_0000;
    end else begin
      if (redirect) begin
        r_pc <= w_redirect_tgt;
      end else if (w_grant) begin
        r_pc <= r_pc + 32'd4;
      end else begin
        r_pc <= r_pc;
      end
      if (w_grant) begin
        r_issue_pc <= r_pc;
      end else begin
        r_issue_pc <= r_issue_pc;
      end
    end
  end

  // Output buffer toward the decoder; held stable until it is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_issue_pc;
      end else begin
        r_instr    <= r_instr;
        r_instr_pc <= r_instr_pc;
      end
      if (redirect) begin
        r_instr_valid <= 1'b0;
      end else if (w_load) begin
        r_instr_valid <= 1'b1;
      end else if (w_xfer) begin
        r_instr_valid <= 1'b0;
      end else begin
        r_instr_valid <= r_instr_valid;
      end
    end
  end

  // Count of instructions actually accepted by the decoder, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr_count <= 16'h0000;
    end else if (w_xfer) begin
      r_instr_count <= r_instr_count + 16'd1;
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. Inputs change 2 time units
// after each rising edge; outputs are checked 1 time unit later.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [15:0] instr_count;

  int n_tests;
  int n_fail;

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr_count (instr_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},   32'(imem_req),    32'h0);
    chk({tag, "_addr"},  imem_addr,        32'h0);
    chk({tag, "_instr"}, instr,            32'h0);
    chk({tag, "_ipc"},   instr_pc,         32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_count"}, 32'(instr_count), 32'h0);
  endtask

  // Directed stimulus sequence.
  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    halt        = 1'b0;
    #1 rst = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk_reset_values("rst_init");

    // ---- Scenario 1: back-to-back fetches with a one-cycle memory ----
    rst = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    #1;
    chk("s1_first_req",  32'(imem_req), 32'h1);
    chk("s1_first_addr", imem_addr,     32'h0);
    next_cycle();                                   // granted @0 -> WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0A1D_CD73;
    #1;
    chk("s1_wait_req",   32'(imem_req),    32'h0);
    chk("s1_wait_valid", 32'(instr_valid), 32'h0);
    next_cycle();                                   // FULL
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("s1_i0_valid", 32'(instr_valid), 32'h1);
    chk("s1_i0_data",  instr,            32'h0A1D_CD73);
    chk("s1_i0_pc",    instr_pc,         32'h0);
    chk("s1_full_req", 32'(imem_req),    32'h0);
    next_cycle();                                   // transfer -> IDLE
    #1;
    chk("s1_cnt1",    32'(instr_count), 32'h1);
    chk("s1_idle_v",  32'(instr_valid), 32'h0);
    chk("s1_req2",    32'(imem_req),    32'h1);
    chk("s1_addr2",   imem_addr,        32'h4);
    next_cycle();                                   // granted @4 -> WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2A1D_CD73;
    #1;
    chk("s1_wait2_v", 32'(instr_valid), 32'h0);
    next_cycle();                                   // FULL
    imem_rvalid = 1'b0;
    #1;
    chk("s1_i1_valid", 32'(instr_valid), 32'h1);
    chk("s1_i1_data",  instr,            32'h2A1D_CD73);
    chk("s1_i1_pc",    instr_pc,         32'h4);
    next_cycle();                                   // transfer
    instr_ready = 1'b0;
    #1;
    chk("s1_cnt2",  32'(instr_count), 32'h2);
    chk("s1_v_off", 32'(instr_valid), 32'h0);
    chk("s1_addr3", imem_addr,        32'h8);

    // ---- Scenario 2: decoder stalls for 5 cycles while FULL ----
    imem_gnt = 1'b1;
    next_cycle();                                   // granted @8 -> WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    next_cycle();                                   // FULL
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s2_stall_data",  instr,            32'h1111_2222);
      chk("s2_stall_pc",    instr_pc,         32'h8);
      chk("s2_stall_valid", 32'(instr_valid), 32'h1);
      chk("s2_stall_req",   32'(imem_req),    32'h0);
      next_cycle();
    end
    instr_ready = 1'b1;
    #1;
    chk("s2_pre_cnt", 32'(instr_count), 32'h2);
    next_cycle();                                   // single transfer
    #1;
    chk("s2_cnt3",  32'(instr_count), 32'h3);
    chk("s2_v_off", 32'(instr_valid), 32'h0);
    next_cycle();
    #1;
    chk("s2_cnt_hold", 32'(instr_count), 32'h3);

    // ---- Scenario 3: redirect while WAIT, late response discarded ----
    imem_gnt = 1'b1;
    #1;
    chk("s3_addr_c", imem_addr, 32'hC);
    next_cycle();                                   // granted @C -> WAIT
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("s3_redir_req", 32'(imem_req), 32'h0);
    next_cycle();                                   // WAIT with drop
    redirect = 1'b0;
    #1;
    chk("s3_wait_addr", imem_addr,     32'h0000_0100);
    chk("s3_wait_req",  32'(imem_req), 32'h0);
    next_cycle();                                   // still WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    next_cycle();                                   // response dropped -> IDLE
    imem_rvalid = 1'b0;
    #1;
    chk("s3_no_valid", 32'(instr_valid), 32'h0);
    chk("s3_no_data",  instr,            32'h1111_2222);
    chk("s3_req",      32'(imem_req),    32'h1);
    chk("s3_addr",     imem_addr,        32'h0000_0100);
    chk("s3_cnt",      32'(instr_count), 32'h3);
    next_cycle();
    #1;
    chk("s3_still_no_valid", 32'(instr_valid), 32'h0);

    // ---- Scenario 4: redirect and ready together in FULL ----
    instr_ready = 1'b0; imem_gnt = 1'b1;
    next_cycle();                                   // granted @100 -> WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_4444;
    next_cycle();                                   // FULL
    imem_rvalid = 1'b0;
    #1;
    chk("s4_full_valid", 32'(instr_valid), 32'h1);
    chk("s4_full_pc",    instr_pc,         32'h0000_0100);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b1;
    next_cycle();
    redirect = 1'b0; instr_ready = 1'b0;
    #1;
    chk("s4_valid", 32'(instr_valid), 32'h0);
    chk("s4_cnt",   32'(instr_count), 32'h3);
    chk("s4_req",   32'(imem_req),    32'h1);
    chk("s4_addr",  imem_addr,        32'h0000_0200);

    // ---- Scenario 5: fetch at top of address space wraps to 0 ----
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    next_cycle();
    redirect = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("s5_addr_top", imem_addr,     32'hFFFF_FFFC);
    chk("s5_req_top",  32'(imem_req), 32'h1);
    next_cycle();                                   // granted @FFFFFFFC
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_6666;
    #1;
    chk("s5_addr_wrap", imem_addr, 32'h0);
    next_cycle();                                   // FULL
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    #1;
    chk("s5_pc",   instr_pc, 32'hFFFF_FFFC);
    chk("s5_data", instr,    32'h5555_6666);
    next_cycle();
    instr_ready = 1'b0;
    #1;
    chk("s5_cnt", 32'(instr_count), 32'h4);

    // ---- Scenario 6: halt during WAIT, then reset mid-WAIT ----
    imem_gnt = 1'b1;
    next_cycle();                                   // granted @0 -> WAIT
    halt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h7777_8888;
    #1;
    chk("s6_halt_req", 32'(imem_req), 32'h0);
    next_cycle();                                   // FULL despite halt
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    #1;
    chk("s6_valid", 32'(instr_valid), 32'h1);
    chk("s6_data",  instr,            32'h7777_8888);
    chk("s6_pc",    instr_pc,         32'h0);
    next_cycle();                                   // delivered under halt
    instr_ready = 1'b0;
    #1;
    chk("s6_cnt",      32'(instr_count), 32'h5);
    chk("s6_idle_req", 32'(imem_req),    32'h0);
    next_cycle();
    #1;
    chk("s6_halt_req2",  32'(imem_req), 32'h0);
    chk("s6_halt_addr",  imem_addr,     32'h4);
    halt = 1'b0;
    #1;
    chk("s6_unhalt_req", 32'(imem_req), 32'h1);
    next_cycle();                                   // granted @4 -> WAIT
    imem_gnt = 1'b0;
    #1;
    chk("s6_wait_addr", imem_addr, 32'h8);
    rst = 1'b0;
    #1;
    chk_reset_values("s6_rst");
    next_cycle();
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h9999_AAAA;
    #1;
    chk("s6_post_req",  32'(imem_req), 32'h1);
    chk("s6_post_addr", imem_addr,     32'h0);
    next_cycle();                                   // stray response ignored
    imem_rvalid = 1'b0;
    #1;
    chk("s6_late_valid", 32'(instr_valid), 32'h0);
    chk("s6_late_instr", instr,            32'h0);
    chk("s6_late_req",   32'(imem_req),    32'h1);
    chk("s6_late_addr",  imem_addr,        32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the byte address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  byte address of the request; valid while imem_req=1.
REQ-006 imem_gnt  input  1  memory accepts the request in the cycle where imem_req=1 and imem_gnt=1.
REQ-007 imem_rvalid  input  1  read response valid; always in order; at most one per granted request.
REQ-008 imem_rdata  input  32  instruction word; valid while imem_rvalid=1.
REQ-009 instr  output  32  fetched instruction word, driven to the decoder.
REQ-010 instr_pc  output  32  byte address of instr.
REQ-011 instr_valid  output  1  instr and instr_pc hold a deliverable instruction.
REQ-012 instr_ready  input  1  the decoder accepts; a transfer occurs when instr_valid=1 and instr_ready=1.
REQ-013 redirect  input  1  branch/jump taken; single-cycle pulse.
REQ-014 redirect_pc  input  32  branch/jump target; sampled only when redirect=1.
REQ-015 halt  input  1  level; while 1, no new requests are issued.
REQ-016 instr_count  output  16  number of completed transfers, modulo 2^16.

Function
REQ-017 The FSM SHALL have three states: IDLE (ready to issue), WAIT (one request outstanding), FULL (output register holds an instruction).
REQ-018 imem_req SHALL be 1 only when state=IDLE, halt=0 and redirect=0; imem_addr SHALL equal the pc register.
REQ-019 IDLE with a grant: issue_pc<=pc; pc<=pc+4 (32-bit wrap, so 32'hFFFF_FFFC+4 gives 0); next state WAIT.
REQ-020 IDLE without a grant: hold state and pc; imem_req stays asserted while the conditions in REQ-018 hold.
REQ-021 WAIT with imem_rvalid=1 and drop=0: instr<=imem_rdata; instr_pc<=issue_pc; instr_valid<=1; next state FULL.
REQ-022 WAIT with imem_rvalid=1 and drop=1: discard the data; clear drop; next state IDLE.
REQ-023 FULL: instr, instr_pc and instr_valid SHALL stay stable until a transfer occurs; on a transfer, instr_valid<=0 and next state IDLE.
REQ-024 Minimum latency: grant in cycle N, rvalid in N+1, instr_valid=1 from N+2. Sustained throughput is one instruction per 3 cycles when memory responds in one cycle.
REQ-025 redirect=1 SHALL take priority over every other event in the same cycle: pc<=redirect_pc with bits [1:0] forced to 00, and instr_valid<=0.
REQ-026 redirect effect by state:
  - IDLE -> IDLE.
  - FULL -> IDLE; the buffered instruction is dropped and instr_count is not incremented, even if instr_ready=1.
  - WAIT without rvalid -> WAIT with drop<=1.
  - WAIT with rvalid in the same cycle -> IDLE with the response discarded.
REQ-027 halt=1 SHALL only suppress new requests: an outstanding response still completes, and a FULL instruction is still delivered.
REQ-028 instr_count SHALL increment by 1 on each transfer and wrap from 16'hFFFF to 0.
REQ-029 imem_rvalid received in IDLE or FULL is a protocol violation and SHALL be ignored with no state change.

Reset
REQ-030 While rst=0, outputs SHALL immediately take these values:
  - state=IDLE, pc=RESET_PC, issue_pc=0, drop=0.
  - instr=0, instr_pc=0, instr_valid=0, instr_count=0.
  - imem_req=0 while in reset; imem_addr=RESET_PC.
REQ-031 Reset asserted in WAIT SHALL abandon the request; a late imem_rvalid arriving after reset release SHALL be ignored per REQ-029.
REQ-032 The first request after reset release SHALL be issued in the first clock edge cycle with rst=1, halt=0 and redirect=0.

Verification
REQ-033 Bench scenarios, one line each:
  - Reset release, 1-cycle memory returning 32'h0A1DCD73 then 32'h2A1DCD73, instr_ready=1: instr_pc=0 then 4, data matches, instr_count=2, instr_valid is high every third cycle.
  - instr_ready=0 for 5 cycles while FULL: instr/instr_pc stable and imem_req=0 throughout; release -> exactly one transfer.
  - redirect to 32'h0000_0103 in WAIT, rvalid 2 cycles later with 32'hDEADBEEF: data is never delivered; next imem_addr=32'h0000_0100.
  - redirect and instr_ready asserted together in FULL: no transfer, instr_count unchanged, next request to the target.
  - pc=32'hFFFF_FFFC granted: instr_pc=32'hFFFF_FFFC, next imem_addr=0.
  - halt=1 asserted in WAIT: response is delivered, then imem_req stays 0 until halt=0; rst pulsed low mid-WAIT -> all outputs equal the reset values of REQ-030.
